// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module : seg7_pkg
//  Brief  : Seven-segment constants, digit encoding and FSM state type for
//           the sequential binary-to-decimal display path.
//  Rev    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Active-low, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    // Decimal digit to active-low segment pattern; non-decimal codes blank
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2seg_seq_if.sv
`default_nettype none
// ============================================================================
//  Module : bin2seg_seq_if
//  Brief  : Request/response bundle between the input sampling logic (master)
//           and the binary-to-seven-segment converter (slave).
//  Rev    : 1.0  initial release
// ============================================================================
interface bin2seg_seq_if #(
    parameter int DATA_W = 10,
    parameter int DIGITS = 4
);
    logic [DATA_W-1:0]   value;
    logic                signed_mode;
    logic                start;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [DIGITS*7-1:0] seg;

    modport master (
        output value, signed_mode, start,
        input  busy, done, ovf, seg
    );

    modport slave (
        input  value, signed_mode, start,
        output busy, done, ovf, seg
    );
endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module : seg7_decoder
//  Brief  : Combinational single-digit decoder, 4-bit BCD to active-low
//           seven segments (g..a).
//  Rev    : 1.0  initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  wire logic [3:0] digit,
    output logic      [6:0] seg
);

    // Pure table lookup
    assign seg = seg7_encode(digit);

endmodule
`default_nettype wire

// File: rtl/bin2seg_seq.sv
`default_nettype none
// ============================================================================
//  Module : bin2seg_seq
//  Brief  : Iterative (double-dabble) binary to decimal converter driving
//           DIGITS active-low seven-segment displays, with leading-zero
//           blanking, a placed minus sign and overflow indication.
//  Rev    : 1.0  initial release
// ============================================================================
module bin2seg_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DIGITS = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bin2seg_seq_if.slave  bus
);

    localparam int BCD_N = (DATA_W * 3) / 10 + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sign;
    logic [DATA_W-1:0]     r_mag;
    logic [4*BCD_N-1:0]    r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIGITS*7-1:0]   r_seg;
    logic                  r_ovf;
    logic                  r_done;

    logic                  w_sign_in;
    logic [DATA_W-1:0]     w_neg;
    logic [4*BCD_N-1:0]    w_bcd_adj;
    int                    w_sig;
    int                    w_avail;
    logic                  w_ovf;
    logic [DIGITS*7-1:0]   w_dec;
    logic [DIGITS*7-1:0]   w_seg_fmt;

    assign w_sign_in = bus.signed_mode & bus.value[DATA_W-1];
    // Two's-complement negate; the most negative value wraps to its own
    // magnitude when read as unsigned, which is what we want.
    assign w_neg     = (~bus.value) + {{(DATA_W-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = FORMAT;
            FORMAT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < BCD_N; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Significant digit count (at least one so zero shows as '0')
    always_comb begin
        w_sig = 1;
        for (int k = 0; k < BCD_N; k++) begin
            if (r_bcd[4*k +: 4] != 4'd0) w_sig = k + 1;
        end
    end

    assign w_avail = r_sign ? DIGITS - 1 : DIGITS;
    assign w_ovf   = (w_sig > w_avail);

    // One decoder per display; displays beyond the BCD width decode blank
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dec
            logic [3:0] w_digit;
            if (i < BCD_N) begin : g_bcd
                assign w_digit = r_bcd[4*i +: 4];
            end else begin : g_none
                assign w_digit = 4'hF;
            end
            seg7_decoder u_dec (
                .digit (w_digit),
                .seg   (w_dec[7*i +: 7])
            );
        end
    endgenerate

    // Display composition: digits, then optional minus, then blanks
    always_comb begin
        w_seg_fmt = {DIGITS{SEG_BLANK}};
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ovf) begin
                w_seg_fmt[7*i +: 7] = SEG_MINUS;
            end else if (i < w_sig) begin
                w_seg_fmt[7*i +: 7] = w_dec[7*i +: 7];
            end else if ((i == w_sig) && r_sign) begin
                w_seg_fmt[7*i +: 7] = SEG_MINUS;
            end else begin
                w_seg_fmt[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    // Datapath: operand capture, shift-and-add-3 iterations, result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_seg  <= {DIGITS{SEG_BLANK}};
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_sign_in ? w_neg : bus.value;
                        r_bcd  <= '0;
                        r_cnt  <= CNT_W'(DATA_W);
                    end
                end
                SHIFT: begin
                    {r_bcd, r_mag} <= {w_bcd_adj[4*BCD_N-2:0], r_mag, 1'b0};
                    r_cnt          <= r_cnt - CNT_W'(1);
                end
                FORMAT: begin
                    r_seg  <= w_seg_fmt;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_bin2seg_seq.sv
`default_nettype none
// ============================================================================
//  Module : tb_bin2seg_seq
//  Brief  : Directed self-checking bench for bin2seg_seq; a 4-display and a
//           3-display instance share the same stimulus.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_bin2seg_seq;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] SM = 7'b0111111;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   lat;
    int   cnt;

    bin2seg_seq_if #(.DATA_W(10), .DIGITS(4)) ifa ();
    bin2seg_seq_if #(.DATA_W(10), .DIGITS(3)) ifb ();

    assign ifb.value       = ifa.value;
    assign ifb.signed_mode = ifa.signed_mode;
    assign ifb.start       = ifa.start;

    bin2seg_seq #(.DATA_W(10), .DIGITS(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    bin2seg_seq #(.DATA_W(10), .DIGITS(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and measure edges until done (bounded)
    task automatic conv(input logic [9:0] v, input logic sm, output int n);
        @(negedge clk);
        ifa.value       = v;
        ifa.signed_mode = sm;
        ifa.start       = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        n = 0;
        while (ifa.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        ifa.value       = '0;
        ifa.signed_mode = 1'b0;
        ifa.start       = 1'b0;

        #12;
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_done", ifa.done, 1'b0);
        chk("rst_ovf",  ifa.ovf,  1'b0);
        chk("rst_seg",  ifa.seg,  {SB, SB, SB, SB});
        @(negedge clk);
        rst_n = 1'b1;

        // 15 unsigned
        conv(10'd15, 1'b0, lat);
        chk("lat_15",  lat, 11);
        chk("seg_15",  ifa.seg, {SB, SB, S1, S5});
        chk("ovf_15",  ifa.ovf, 1'b0);
        @(posedge clk); #1;
        chk("done_pulse", ifa.done, 1'b0);

        // 1023 unsigned, overflow on three displays
        conv(10'h3FF, 1'b0, lat);
        chk("seg_1023",   ifa.seg, {S1, S0, S2, S3});
        chk("ovf_1023",   ifa.ovf, 1'b0);
        chk("segB_1023",  ifb.seg, {SM, SM, SM});
        chk("ovfB_1023",  ifb.ovf, 1'b1);

        // -1
        conv(10'h3FF, 1'b1, lat);
        chk("seg_m1",  ifa.seg, {SB, SB, SM, S1});
        chk("ovf_m1",  ifa.ovf, 1'b0);

        // -512, most negative value
        conv(10'h200, 1'b1, lat);
        chk("seg_m512", ifa.seg, {SM, S5, S1, S2});
        chk("ovf_m512", ifa.ovf, 1'b0);

        // zero in signed mode never shows a minus
        conv(10'h000, 1'b1, lat);
        chk("seg_zero", ifa.seg, {SB, SB, SB, S0});
        chk("ovf_zero", ifa.ovf, 1'b0);

        // -116 on three displays: three digits, two available
        conv(10'h38C, 1'b1, lat);
        chk("segB_m116", ifb.seg, {SM, SM, SM});
        chk("ovfB_m116", ifb.ovf, 1'b1);
        chk("seg_m116",  ifa.seg, {SM, S1, S1, 7'b0000010});

        // -99 exactly fits three displays
        conv(10'h39D, 1'b1, lat);
        chk("segB_m99", ifb.seg, {SM, S9, S9});
        chk("ovfB_m99", ifb.ovf, 1'b0);

        // start re-pulsed while busy is ignored
        @(negedge clk);
        ifa.value = 10'd42; ifa.signed_mode = 1'b0; ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ifa.value = 10'd7; ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        cnt = 0;
        repeat (24) begin
            @(posedge clk);
            #1 if (ifa.done === 1'b1) cnt++;
        end
        chk("ign_done_cnt", cnt, 1);
        chk("ign_seg", ifa.seg, {SB, SB, S4, S2});

        // start held high: back-to-back conversions
        @(negedge clk);
        ifa.value = 10'd5; ifa.signed_mode = 1'b0; ifa.start = 1'b1;
        cnt = 0;
        while (ifa.done !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("held_first", cnt < 40, 1'b1);
        cnt = 0;
        do begin
            @(posedge clk);
            #1 cnt++;
        end while (ifa.done !== 1'b1 && cnt < 40);
        chk("held_period", cnt, 12);
        chk("held_seg", ifa.seg, {SB, SB, SB, S5});
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_stop", ifa.busy, 1'b0);

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        ifa.value = 10'd999; ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_busy", ifa.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", ifa.busy, 1'b0);
        chk("arst_done", ifa.done, 1'b0);
        chk("arst_seg",  ifa.seg,  {SB, SB, SB, SB});
        chk("arst_segB", ifb.seg,  {SB, SB, SB});
        @(negedge clk);
        rst_n = 1'b1;
        conv(10'd321, 1'b0, lat);
        chk("post_lat", lat, 11);
        chk("post_seg", ifa.seg, {SB, S3, S2, S1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
